// File: rtl/click_decoder_if.sv
// Click decoder bus: debounced press input and decoded click strobes / mode index.
interface click_decoder_if #(
    parameter int unsigned MODE_W = 2
);
    logic              pb_in;
    logic              single_click;
    logic              double_click;
    logic              busy;
    logic [MODE_W-1:0] mode;

    modport master (
        output pb_in,
        input  single_click,
        input  double_click,
        input  busy,
        input  mode
    );

    modport slave (
        input  pb_in,
        output single_click,
        output double_click,
        output busy,
        output mode
    );
endinterface

// File: rtl/click_decoder.sv
// Classifies debounced presses as single or double clicks within a time window
// and steps a wrap-around mode index forward (single) or back (double).
module click_decoder #(
    parameter int unsigned WINDOW_CYCLES = 30_000_000,
    parameter int unsigned MODES         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    click_decoder_if.slave  bus
);
    localparam int unsigned MODE_W = (MODES > 1) ? $clog2(MODES) : 1;
    localparam int unsigned CNT_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MODE_W-1:0] mode_q;
    logic              single_q;
    logic              double_q;
    logic              busy_q;
    logic              pb_d;

    logic              rise_c;
    logic [MODE_W-1:0] mode_inc_c;
    logic [MODE_W-1:0] mode_dec_c;

    assign rise_c     = bus.pb_in & ~pb_d;
    assign mode_inc_c = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
    assign mode_dec_c = (mode_q == '0) ? MODE_LAST : mode_q - MODE_W'(1);

    // pb_d resets high so a button held through reset release is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
            pb_d     <= 1'b1;
        end else begin
            pb_d     <= bus.pb_in;
            single_q <= 1'b0;
            double_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rise_c) begin
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // a second rise wins over a coincident window timeout
                    if (rise_c) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        double_q <= 1'b1;
                        mode_q   <= mode_dec_c;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        single_q <= 1'b1;
                        mode_q   <= mode_inc_c;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.single_click = single_q;
    assign bus.double_click = double_q;
    assign bus.busy         = busy_q;
    assign bus.mode         = mode_q;
endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder with WINDOW_CYCLES=10, MODES=3.
module tb_click_decoder;
    localparam int unsigned W      = 10;
    localparam int unsigned MODES  = 3;
    localparam int unsigned MODE_W = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    click_decoder_if #(.MODE_W(MODE_W)) bus ();

    click_decoder #(.WINDOW_CYCLES(W), .MODES(MODES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              seq   [$];
    logic              obs_s [$];
    logic              obs_d [$];
    logic              obs_b [$];
    logic [MODE_W-1:0] obs_m [$];
    logic              exp_s [$];
    logic              exp_d [$];
    logic              exp_b [$];
    int                exp_m [$];

    task automatic apply_reset(input logic pb_level);
        @(negedge clk);
        bus.pb_in = pb_level;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Drive seq[i] during cycle i; obs[i] holds the outputs seen before seq[i] is applied.
    task automatic run_seq();
        obs_s.delete(); obs_d.delete(); obs_b.delete(); obs_m.delete();
        foreach (seq[i]) begin
            @(negedge clk);
            obs_s.push_back(bus.single_click);
            obs_d.push_back(bus.double_click);
            obs_b.push_back(bus.busy);
            obs_m.push_back(bus.mode);
            bus.pb_in = seq[i];
        end
        @(negedge clk);
        obs_s.push_back(bus.single_click);
        obs_d.push_back(bus.double_click);
        obs_b.push_back(bus.busy);
        obs_m.push_back(bus.mode);
    endtask

    // Timestamp model: a sequence opened at cycle s closes as double on the next rise,
    // or as single once s+W passes without one.
    task automatic model_seq(input logic prev0, input int m0, output int m_end);
        int   start;
        int   m;
        logic prev;
        logic rise;
        logic s;
        logic d;
        start = -1;
        m     = m0;
        prev  = prev0;
        exp_s.delete(); exp_d.delete(); exp_b.delete(); exp_m.delete();
        exp_s.push_back(1'b0); exp_d.push_back(1'b0); exp_b.push_back(1'b0); exp_m.push_back(m);
        foreach (seq[i]) begin
            rise = seq[i] && !prev;
            prev = seq[i];
            s = 1'b0;
            d = 1'b0;
            if (start < 0) begin
                if (rise) start = i;
            end else if (rise) begin
                d = 1'b1;
                m = (m + MODES - 1) % MODES;
                start = -1;
            end else if (i - start == W) begin
                s = 1'b1;
                m = (m + 1) % MODES;
                start = -1;
            end
            exp_s.push_back(s);
            exp_d.push_back(d);
            exp_b.push_back(start >= 0);
            exp_m.push_back(m);
        end
        m_end = m;
    endtask

    task automatic build_pulses(input int len, input int r0, input int w0, input int r1, input int w1);
        seq.delete();
        for (int i = 0; i < len; i++)
            seq.push_back(((i >= r0) && (i < r0 + w0)) || ((r1 >= 0) && (i >= r1) && (i < r1 + w1)));
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.pb_in = 1'b0;
        rst_n     = 1'b0;
        #2;
        total++; if (bus.single_click !== 1'b0) begin bad++; $display("FAIL reset_single got=%b want=0", bus.single_click); end
        total++; if (bus.double_click !== 1'b0) begin bad++; $display("FAIL reset_double got=%b want=0", bus.double_click); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", bus.mode); end
        apply_reset(1'b0);
    endtask

    task automatic test_single();
        apply_reset(1'b0);
        build_pulses(20, 2, 3, -1, 0);
        run_seq();
        for (int i = 0; i <= 20; i++) begin
            total++;
            if (obs_s[i] !== (i == 13) || obs_d[i] !== 1'b0 || obs_b[i] !== (i >= 3 && i <= 12)) begin
                bad++;
                $display("FAIL single cyc=%0d got s=%b d=%b b=%b want s=%b d=0 b=%b",
                         i, obs_s[i], obs_d[i], obs_b[i], i == 13, i >= 3 && i <= 12);
            end
        end
        total++; if (obs_m[12] !== 2'd0) begin bad++; $display("FAIL single_mode_before got=%0d want=0", obs_m[12]); end
        total++; if (obs_m[13] !== 2'd1) begin bad++; $display("FAIL single_mode_after got=%0d want=1", obs_m[13]); end
    endtask

    task automatic test_double();
        apply_reset(1'b0);
        build_pulses(20, 2, 2, 7, 2);
        run_seq();
        for (int i = 0; i <= 20; i++) begin
            total++;
            if (obs_d[i] !== (i == 8) || obs_s[i] !== 1'b0) begin
                bad++;
                $display("FAIL double cyc=%0d got s=%b d=%b want s=0 d=%b", i, obs_s[i], obs_d[i], i == 8);
            end
        end
        total++; if (obs_m[8] !== 2'd2) begin bad++; $display("FAIL double_mode_wrap got=%0d want=2", obs_m[8]); end
    endtask

    task automatic test_mode_wrap();
        apply_reset(1'b0);
        seq.delete();
        for (int i = 0; i < 55; i++) seq.push_back(i == 2 || i == 20 || i == 38);
        run_seq();
        for (int i = 0; i <= 55; i++) begin
            total++;
            if (obs_s[i] !== (i == 13 || i == 31 || i == 49) || obs_d[i] !== 1'b0) begin
                bad++;
                $display("FAIL wrap_strobe cyc=%0d got s=%b d=%b", i, obs_s[i], obs_d[i]);
            end
        end
        total++; if (obs_m[13] !== 2'd1) begin bad++; $display("FAIL wrap_mode1 got=%0d want=1", obs_m[13]); end
        total++; if (obs_m[31] !== 2'd2) begin bad++; $display("FAIL wrap_mode2 got=%0d want=2", obs_m[31]); end
        total++; if (obs_m[49] !== 2'd0) begin bad++; $display("FAIL wrap_mode0 got=%0d want=0", obs_m[49]); end
        total++; if (obs_m[48] !== 2'd2) begin bad++; $display("FAIL wrap_mode_pre got=%0d want=2", obs_m[48]); end
    endtask

    task automatic test_timeout_tie();
        apply_reset(1'b0);
        build_pulses(25, 2, 3, 12, 2);
        run_seq();
        for (int i = 0; i <= 25; i++) begin
            total++;
            if (obs_d[i] !== (i == 13) || obs_s[i] !== 1'b0) begin
                bad++;
                $display("FAIL tie cyc=%0d got s=%b d=%b want s=0 d=%b", i, obs_s[i], obs_d[i], i == 13);
            end
        end
        total++; if (obs_m[13] !== 2'd2) begin bad++; $display("FAIL tie_mode got=%0d want=2", obs_m[13]); end
    endtask

    task automatic test_held_at_reset();
        apply_reset(1'b1);
        seq.delete();
        for (int i = 0; i < 40; i++) seq.push_back(i < 20 || i == 22);
        run_seq();
        for (int i = 0; i <= 40; i++) begin
            total++;
            if (obs_s[i] !== (i == 33) || obs_d[i] !== 1'b0 || obs_b[i] !== (i >= 23 && i <= 32)) begin
                bad++;
                $display("FAIL held cyc=%0d got s=%b d=%b b=%b", i, obs_s[i], obs_d[i], obs_b[i]);
            end
        end
        total++; if (obs_m[33] !== 2'd1) begin bad++; $display("FAIL held_mode got=%0d want=1", obs_m[33]); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(1'b0);
        build_pulses(20, 2, 1, -1, 0);
        run_seq();
        total++; if (obs_m[20] !== 2'd1) begin bad++; $display("FAIL abort_setup_mode got=%0d want=1", obs_m[20]); end
        @(negedge clk); bus.pb_in = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.pb_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b want=1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL abort_mode got=%0d want=0", bus.mode); end
        @(negedge clk);
        rst_n = 1'b1;
        seq.delete();
        for (int i = 0; i < 15; i++) seq.push_back(1'b0);
        run_seq();
        for (int i = 0; i <= 15; i++) begin
            total++;
            if (obs_s[i] !== 1'b0 || obs_d[i] !== 1'b0 || obs_b[i] !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cyc=%0d got s=%b d=%b b=%b", i, obs_s[i], obs_d[i], obs_b[i]);
            end
        end
        build_pulses(20, 2, 3, -1, 0);
        run_seq();
        for (int i = 0; i <= 20; i++) begin
            total++;
            if (obs_s[i] !== (i == 13) || obs_d[i] !== 1'b0 || obs_m[i] !== ((i >= 13) ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL abort_recover cyc=%0d got s=%b d=%b m=%0d", i, obs_s[i], obs_d[i], obs_m[i]);
            end
        end
    endtask

    task automatic test_random();
        int m;
        int m_end;
        int gap;
        int hi;
        apply_reset(1'b0);
        m = 0;
        for (int it = 0; it < 8; it++) begin
            seq.delete();
            while (seq.size() < 100) begin
                gap = $urandom_range(1, 14);
                hi  = $urandom_range(1, 4);
                for (int k = 0; k < gap; k++) seq.push_back(1'b0);
                for (int k = 0; k < hi; k++) seq.push_back(1'b1);
            end
            for (int k = 0; k < 15; k++) seq.push_back(1'b0);
            model_seq(1'b0, m, m_end);
            run_seq();
            foreach (exp_s[i]) begin
                total++;
                if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_b[i] !== exp_b[i]
                    || obs_m[i] !== MODE_W'(exp_m[i])) begin
                    bad++;
                    $display("FAIL random it=%0d cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                             it, i, obs_s[i], obs_d[i], obs_b[i], obs_m[i],
                             exp_s[i], exp_d[i], exp_b[i], exp_m[i]);
                end
            end
            m = m_end;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.pb_in = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_mode_wrap();
        test_timeout_tie();
        test_held_at_reset();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/click_decoder.md
Name: click_decoder

Overview:
- Sits directly downstream of the push-button debouncer.
- Consumes the debounced press pulse `pb_in`. That pulse is a multi-cycle high level on `clk` (one slow-enable period long).
- Classifies each press sequence as a single click or a double click using a configurable time window.
- Keeps a wrap-around mode index that the display controller uses for page/menu selection: single click steps forward, double click steps back.

Parameters:
- WINDOW_CYCLES, 30_000_000, double-click window in clk cycles (300 ms at 100 MHz). Legal range ≥ 2.
- MODES, 4, number of mode values. Legal range ≥ 2.
- MODE_W, derived localparam: clog2(MODES), minimum 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- pb_in  input  1  debounced press pulse from the debouncer; synchronous to clk.
- single_click  output  1  one-cycle strobe: single click decided.
- double_click  output  1  one-cycle strobe: double click decided.
- busy  output  1  high while a click sequence is pending (state WAIT).
- mode  output  MODE_W  current mode index, 0..MODES-1.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low. All outputs are registered.

Reset values:
- State = IDLE, window counter = 0, mode = 0, single_click = 0, double_click = 0, busy = 0.
- Edge register pb_d resets to 1. A pb_in already high when reset releases therefore produces no event until it falls and rises again.

Edge detect:
- rise = pb_in & ~pb_d; pb_d <= pb_in every cycle.
- Only rising edges matter. Pulse width is irrelevant.

FSM, two states:
- IDLE:
  - rise → WAIT, counter <= 0.
  - No rise → stay.
- WAIT:
  - rise → IDLE, double_click <= 1.
  - Else, counter == WINDOW_CYCLES-1 → IDLE, single_click <= 1.
  - Else, counter <= counter+1.
- A rise on the same cycle as the timeout resolves as a double click. Rise has priority.
- A third rise after a double click starts a new sequence from IDLE.

Timing:
- First rise seen in cycle t0.
- Single click: single_click is high in cycle t0+WINDOW_CYCLES+1.
- Double click, second rise seen in cycle t1: double_click is high in cycle t1+1.
- Each strobe is exactly one cycle wide. single_click and double_click are never high together.

Busy and counter:
- busy = 1 exactly while state == WAIT, registered together with the state.
- Counter width is clog2(WINDOW_CYCLES).
- Counter never exceeds WINDOW_CYCLES-1 and holds 0 in IDLE.

Mode update:
- Updates on the same edge that raises a strobe, so the new value is visible in the strobe cycle.
- Single click: mode+1, wraps MODES-1 → 0.
- Double click: mode-1, wraps 0 → MODES-1.
- Applies to non-power-of-2 MODES as well; no out-of-range value ever appears.

Reset mid-operation:
- Asserting rst_n low in WAIT aborts the sequence: no strobe, mode → 0, immediately (asynchronous).
- After release, a held-high pb_in generates no event.

Test Plan (WINDOW_CYCLES=10, MODES=3):
1. Reset, then one pb_in pulse 3 cycles wide, first high in cycle t0 → single_click high only in cycle t0+11; busy high cycles t0+1..t0+10; mode 0→1.
2. Two pulses with rising edges at t0 and t0+5 → double_click high only in cycle t0+6; no single_click; mode 0→2 (wrap down).
3. Three separated single clicks → mode 1, 2, then 0 (wrap up), each in its strobe cycle.
4. Second rise coinciding with the timeout cycle (edge at t0+10) → double_click at t0+11; single_click never asserted.
5. pb_in held high across rst_n release, then held 20 cycles → no strobe, busy stays 0; after falling and rising again → normal single click.
6. rst_n pulsed low at t0+4 mid-WAIT → no strobe, busy 0, mode 0 immediately; next clean click behaves per scenario 1.
